ternary_fold_seq: RTL
=====================

Name: ternary_fold_seq

Overview:
Sequential operand folder that sits directly upstream of the ternary gate stage (min/max/consensus) and consumes a stream of packed ternary words. It combines a packet of words element-wise into one result word using a selected ternary operation. The result is presented downstream with a valid/ready handshake. Trit encoding matches the gate stage: 00 = 0, 01 = 1, 10 = 2, 11 = invalid.

Parameters:
N_TRITS, 4, trits per word; word width is 2*N_TRITS bits, and trit i occupies bits [2i+1:2i].
CNT_W, 8, width of the word counter (used by the optional feature only).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
op  input  2  fold operation: 00 = min, 01 = max, 10 = consensus, 11 = load (keep last word); sampled with the first word of a packet
in_valid  input  1  upstream word valid
in_ready  output  1  block accepts a word this cycle
in_word  input  2*N_TRITS  packed trit word
in_last  input  1  marks the final word of a packet
out_valid  output  1  result word valid
out_ready  input  1  downstream accepts the result
out_word  output  2*N_TRITS  folded result
out_err  output  1  an invalid trit (11) was seen in this packet
out_count  output  CNT_W  words folded in this packet; present only with TFOLD_COUNT_EN

Behaviour:
- One clock. Reset is asynchronous and active-high: the reset port is rst, the clock port is clk.
- A handshake occurs when in_valid && in_ready at a rising edge. The output transfer occurs when out_valid && out_ready.
- FSM states:
  - IDLE: in_ready=1. On handshake: acc<=sanitised in_word, op_r<=op, err<=any invalid trit. Go to HOLD if in_last, else ACC.
  - ACC: in_ready=1. On handshake: acc<=f(op_r, acc, sanitised in_word), err<=err | invalid. Go to HOLD if in_last.
  - HOLD: in_ready=0, out_valid=1, out_word=acc, out_err=err. On out_ready go to IDLE; the block does not accept a new word in the same cycle.
- in_ready is driven from state and is 0 while rst is asserted. Outputs are unregistered views of the state/acc/err registers.
- Per-trit function f:
  - min: min(a,b)
  - max: max(a,b)
  - consensus: a if a==b, else 1
  - load: b
- Sanitise: an input trit of 11 is replaced by 01 before combining, and err is set.
- The accumulator never holds 11.
- Latency: out_valid asserts on the cycle after the in_last handshake. A single-word packet (in_last on the first word) outputs that word sanitised.
- op changes mid-packet are ignored; op_r holds until the next IDLE capture.
- in_word, in_last and op are don't-care when in_valid=0. Gaps (in_valid low) in ACC hold acc unchanged.
- Backpressure: HOLD persists indefinitely while out_ready=0, with out_word/out_err stable.
- Reset values: state=IDLE, acc=0, err=0, out_valid=0, out_word=0, out_err=0, out_count=0.
- Reset mid-packet or in HOLD discards everything; no partial result is emitted.

Optional Feature:
- Macro: TFOLD_COUNT_EN.
- When defined:
  - Port out_count exists. The counter loads 1 on the first word and increments on each ACC handshake.
  - It saturates at 2^CNT_W-1 (no wrap) and is valid alongside out_valid.
  - It clears to 0 on reset and on the HOLD-to-IDLE transfer.
- When undefined: the port and counter are absent, and the remaining behaviour is identical.

Test Plan:
- Reset then op=00: words 8'b10_01_00_10, 8'b01_10_10_00 (last) -> out_valid the next cycle, out_word=8'b01_01_00_00, out_err=0.
- The same two words with op=01 -> out_word=8'b10_10_10_10. With op=10 -> out_word=8'b01_01_01_01.
- op=00, single word 8'b11_00_10_01 with in_last -> out_word=8'b01_00_10_01, out_err=1. Next packet 8'b00_00_00_00 (last) -> out_err=0.
- op=01, 3 words with in_valid gaps and out_ready held low 5 cycles:
  - in_ready stays 0 in HOLD and out_word is stable.
  - After out_ready=1 for 1 cycle, out_valid=0 and in_ready=1.
  - With TFOLD_COUNT_EN, out_count=3.
- Assert rst after 2 of 4 words -> out_valid never asserts. A following fresh 1-word packet 8'b10_10_10_10 -> out_word=8'b10_10_10_10.
- With TFOLD_COUNT_EN and CNT_W=2: fold 6 words -> out_count=3 (saturated), and the result is still correct.

Source files
------------

// File: rtl/ternary_fold_seq.sv
// ternary_fold_seq: sequential element-wise folder for packed ternary words.
// A packet of words is combined trit-by-trit with min / max / consensus /
// load. The result is offered downstream with a valid/ready handshake.
// Trit encoding: 00=0, 01=1, 10=2, 11=invalid (sanitised to 01 and flagged).
// Optional feature macro: TFOLD_COUNT_EN adds out_count, a saturating count
// of the words folded into the current packet.

// Per-trit lane: sanitise the incoming trit and combine it with the accumulator.
module ternary_fold_trit (
  input  logic [1:0] i_op,
  input  logic [1:0] i_acc,
  input  logic [1:0] i_in,
  output logic [1:0] o_res,
  output logic       o_inv
);
  logic [1:0] w_san;

  assign o_inv = (i_in == 2'b11);
  assign w_san = o_inv ? 2'b01 : i_in;

  // The accumulator never holds 11, so plain unsigned compares order the trits.
  always_comb begin
    o_res = w_san;
    unique case (i_op)
      2'b00:   o_res = (i_acc < w_san) ? i_acc : w_san;
      2'b01:   o_res = (i_acc > w_san) ? i_acc : w_san;
      2'b10:   o_res = (i_acc == w_san) ? i_acc : 2'b01;
      default: o_res = w_san;
    endcase
  end
endmodule

module ternary_fold_seq #(
  parameter int N_TRITS = 4,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             op,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*N_TRITS-1:0]   in_word,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N_TRITS-1:0]   out_word,
  output logic                   out_err
`ifdef TFOLD_COUNT_EN
  ,
  output logic [CNT_W-1:0]       out_count
`endif
);
  localparam int W = 2 * N_TRITS;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC  = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_acc;
  logic [1:0]     r_op;
  logic           r_err;

  logic           w_hs;
  logic [1:0]     w_fold_op;
  logic [W-1:0]   w_fold;
  logic [N_TRITS-1:0] w_inv;
  logic           w_any_inv;

  assign in_ready  = !rst && (r_state != S_HOLD);
  assign w_hs      = in_valid && in_ready;
  assign out_valid = (r_state == S_HOLD);
  assign out_word  = r_acc;
  assign out_err   = r_err;

  // The first word of a packet simply loads (sanitised); later words fold with op_r.
  assign w_fold_op = (r_state == S_IDLE) ? OP_LOAD : r_op;
  assign w_any_inv = |w_inv;

  genvar gi;
  generate
    for (gi = 0; gi < N_TRITS; gi++) begin : g_trit
      ternary_fold_trit u_trit (
        .i_op  (w_fold_op),
        .i_acc (r_acc[2*gi +: 2]),
        .i_in  (in_word[2*gi +: 2]),
        .o_res (w_fold[2*gi +: 2]),
        .o_inv (w_inv[gi])
      );
    end
  endgenerate

  // Packet FSM: capture/fold words in IDLE/ACC, present the result in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_op    <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_acc   <= w_fold;
            r_op    <= op;
            r_err   <= w_any_inv;
            r_state <= in_last ? S_HOLD : S_ACC;
          end
        end
        S_ACC: begin
          if (w_hs) begin
            r_acc <= w_fold;
            r_err <= r_err | w_any_inv;
            if (in_last) r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TFOLD_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  assign out_count = r_cnt;

  // Word counter: 1 on the first word, saturating increment after, clear on transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_hs) r_cnt <= CNT_W'(1);
        S_ACC:  if (w_hs && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
        S_HOLD: if (out_ready) r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end
`endif

endmodule
